// File: rtl/adder_rr_sched.sv
// Round-robin scheduler time-sharing one registered adder among requesters.
// Define ADDER_RR_SCHED_SAT_EN for saturating results and the rsp_ovf_o port.
module adder_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         add_a_o,
    output logic [DATA_W-1:0]         add_b_o,
    input  logic [DATA_W-1:0]         add_res_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_res_o,
`ifdef ADDER_RR_SCHED_SAT_EN
    output logic                      rsp_ovf_o,
`endif
    output logic                      busy_o
);

    localparam int SW = ID_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   ptr_nxt;
    logic              gnt_vld;
    logic [SW-1:0]     scan;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] wait_res;
`ifdef ADDER_RR_SCHED_SAT_EN
    logic              wait_ovf;
`endif

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + SW'(k);
            if (scan >= SW'(NUM_REQ)) begin
                scan = scan - SW'(NUM_REQ);
            end
            if (!gnt_vld && req_valid_i[scan[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
    end

    assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                     : gnt_idx + ID_W'(1);

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && gnt_vld && !reset_i) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

`ifdef ADDER_RR_SCHED_SAT_EN
    // A wrapped sum is smaller than either operand.
    assign wait_ovf = (add_res_i < op_a_q);
    assign wait_res = wait_ovf ? '1 : add_res_i;
`else
    assign wait_res = add_res_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_res_o   <= '0;
`ifdef ADDER_RR_SCHED_SAT_EN
            rsp_ovf_o   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        op_a_q <= req_a_i[gnt_idx*DATA_W +: DATA_W];
                        op_b_q <= req_b_i[gnt_idx*DATA_W +: DATA_W];
                        id_q   <= gnt_idx;
                        ptr_q  <= ptr_nxt;
                    end
                end
                S_ISSUE: ;
                S_WAIT: begin
                    rsp_res_o   <= wait_res;
                    rsp_id_o    <= id_q;
                    rsp_valid_o <= 1'b1;
`ifdef ADDER_RR_SCHED_SAT_EN
                    rsp_ovf_o   <= wait_ovf;
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign add_a_o = op_a_q;
    assign add_b_o = op_b_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: directed scenarios plus randomized traffic
// checked against a transaction-level scheduler model.
module tb_adder_rr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset_i = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_res = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_res;
    logic           busy;
`ifdef ADDER_RR_SCHED_SAT_EN
    logic           rsp_ovf;
    logic           m_ovf = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 idle, 1/2 in flight, 3 response pending.
    int           m_phase = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    logic [W-1:0] m_res = '0;

    adder_rr_sched #(.NUM_REQ(N), .ID_W(IW), .DATA_W(W)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_res_i   (add_res),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_res_o   (rsp_res),
`ifdef ADDER_RR_SCHED_SAT_EN
        .rsp_ovf_o   (rsp_ovf),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // External shared adder with registered operands.
    always @(posedge clk) add_res <= add_a + add_b;

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] one;
        int g;
        one = 1;
        g = exp_grant();
        if (m_phase != 0 || g < 0) return '0;
        return one << g;
    endfunction

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef ADDER_RR_SCHED_SAT_EN
        if (s > 255) return 8'hFF;
`endif
        return s[W-1:0];
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    // Advance the model across the coming edge, then step to edge+1.
    task automatic advance();
        int g;
        case (m_phase)
            0: begin
                g = exp_grant();
                if (g >= 0) begin
                    m_id  = g;
                    m_res = ref_sum(req_a[g*W +: W], req_b[g*W +: W]);
`ifdef ADDER_RR_SCHED_SAT_EN
                    m_ovf = (int'(req_a[g*W +: W]) +
                             int'(req_b[g*W +: W])) > 255;
`endif
                    m_ptr   = (g + 1) % N;
                    m_phase = 1;
                end
            end
            1: m_phase = 2;
            2: m_phase = 3;
            default: if (rsp_ready) m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_i   = 1'b1;
        m_phase   = 0;
        m_ptr     = 0;
        @(posedge clk);
        #1;
        reset_i   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        reset_i   = 1'b1;
        req_valid = '1;
        req_a     = 32'($urandom);
        req_b     = 32'($urandom);
        #2;
        vectors++;
        if ({add_a, add_b, rsp_valid, rsp_id, rsp_res, req_ready, busy}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b busy=%b rsp_valid=%b",
                     req_ready, busy, rsp_valid);
        end
        do_reset();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req_valid = '0;
        set_req(0, 8'h12, 8'h34);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        advance();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (c < 3 && {req_ready, rsp_valid} !== 5'b0) begin
                miscompares++;
                $display("FAIL single_wait%0d: ready=%b rsp_valid=%b",
                         c, req_ready, rsp_valid);
            end
            if (c == 3 && {rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'd0, 8'h46}) begin
                miscompares++;
                $display("FAIL single_rsp: v=%b id=%0d res=%h want 1/0/46",
                         rsp_valid, rsp_id, rsp_res);
            end
            if (c == 3) req_valid = '0;
            advance();
        end
        @(negedge clk);
        vectors++;
        if ({busy, rsp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_done: busy=%b rsp_valid=%b", busy, rsp_valid);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [W-1:0] q_res[$];
        logic [N-1:0] one;
        logic [W-1:0] er;
        int           who;
        one = 1;
        do_reset();
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            req_valid = '1;
            req_a     = 32'($urandom);
            req_b     = 32'($urandom);
            who       = (cyc / 4) % N;
            @(negedge clk);
            vectors++;
            if (req_ready !== ((cyc % 4 == 0) ? one << who : '0)) begin
                miscompares++;
                $display("FAIL rr_grant cyc%0d: got %b want req %0d",
                         cyc, req_ready, who);
            end
            if (cyc % 4 == 0)
                q_res.push_back(ref_sum(req_a[who*W +: W], req_b[who*W +: W]));
            vectors++;
            if (rsp_valid !== (cyc % 4 == 3)) begin
                miscompares++;
                $display("FAIL rr_rsp_valid cyc%0d: got %b", cyc, rsp_valid);
            end
            if (cyc % 4 == 3 && q_res.size() > 0) begin
                er = q_res.pop_front();
                vectors++;
                if ({rsp_id, rsp_res} !== {IW'(who), er}) begin
                    miscompares++;
                    $display("FAIL rr_rsp cyc%0d: id=%0d res=%h want %0d/%h",
                             cyc, rsp_id, rsp_res, who, er);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [IW-1:0] hid;
        logic [W-1:0]  hres;
        do_reset();
        req_valid = '1;
        req_a     = 32'($urandom);
        req_b     = 32'($urandom);
        rsp_ready = 1'b0;
        for (int c = 0; c < 6 && m_phase != 3; c++) advance();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                hid  = rsp_id;
                hres = rsp_res;
            end
            vectors++;
            if ({rsp_valid, rsp_id, rsp_res, req_ready} !==
                {1'b1, IW'(m_id), m_res, 4'b0000}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: v=%b id=%0d res=%h ready=%b want id=%0d res=%h",
                         k, rsp_valid, rsp_id, rsp_res, req_ready, m_id, m_res);
            end
            vectors++;
            if ({rsp_id, rsp_res} !== {hid, hres}) begin
                miscompares++;
                $display("FAIL bp_stable%0d: id=%0d res=%h was %0d/%h",
                         k, rsp_id, rsp_res, hid, hres);
            end
            advance();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        advance();
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready} !== 5'b00010) begin
            miscompares++;
            $display("FAIL bp_release: v=%b ready=%b want 0/0010",
                     rsp_valid, req_ready);
        end
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 8'hFF, 8'h01);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_grant: got %b want 0100", req_ready);
        end
        advance();
        req_valid = '0;
        advance();
        advance();
        @(negedge clk);
        vectors++;
`ifdef ADDER_RR_SCHED_SAT_EN
        if ({rsp_valid, rsp_id, rsp_res, rsp_ovf} !== {1'b1, 2'd2, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_rsp: v=%b id=%0d res=%h ovf=%b want 1/2/ff/1",
                     rsp_valid, rsp_id, rsp_res, rsp_ovf);
        end
`else
        if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'd2, 8'h00}) begin
            miscompares++;
            $display("FAIL wrap_rsp: v=%b id=%0d res=%h want 1/2/00",
                     rsp_valid, rsp_id, rsp_res);
        end
`endif
        advance();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 8'($urandom), 8'($urandom));
        advance();
        req_valid = '0;
        advance();
        @(negedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        vectors++;
        if ({add_a, add_b, rsp_valid, rsp_id, rsp_res, req_ready, busy}
            !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b v=%b a=%h b=%h",
                     busy, rsp_valid, add_a, add_b);
        end
        #1;
        reset_i = 1'b0;
        m_phase = 0;
        m_ptr   = 0;
        advance();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL midreset_norsp%0d: v=%b busy=%b",
                         c, rsp_valid, busy);
            end
            advance();
        end
        req_valid = '1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midreset_regrant: got %b want 0001", req_ready);
        end
        advance();
    endtask

    task automatic test_fairness();
        do_reset();
        rsp_ready = 1'b1;
        set_req(3, 8'($urandom), 8'($urandom));
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL fair_grant3: got %b want 1000", req_ready);
        end
        advance();
        req_valid = '0;
        for (int c = 0; c < 6 && m_phase != 0; c++) advance();
        req_valid = 4'b1001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL fair_grant0: got %b want 0001", req_ready);
        end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 4'($urandom);
            req_a     = 32'($urandom);
            req_b     = 32'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            er        = exp_ready();
            @(negedge clk);
            vectors++;
            if (req_ready !== er) begin
                miscompares++;
                $display("FAIL rand_ready cyc%0d: got %b want %b",
                         cyc, req_ready, er);
            end
            vectors++;
            if ({busy, rsp_valid} !== {m_phase != 0, m_phase == 3}) begin
                miscompares++;
                $display("FAIL rand_state cyc%0d: busy=%b v=%b phase=%0d",
                         cyc, busy, rsp_valid, m_phase);
            end
            if (m_phase == 3) begin
                vectors++;
                if ({rsp_id, rsp_res} !== {IW'(m_id), m_res}) begin
                    miscompares++;
                    $display("FAIL rand_rsp cyc%0d: id=%0d res=%h want %0d/%h",
                             cyc, rsp_id, rsp_res, m_id, m_res);
                end
`ifdef ADDER_RR_SCHED_SAT_EN
                vectors++;
                if (rsp_ovf !== m_ovf) begin
                    miscompares++;
                    $display("FAIL rand_ovf cyc%0d: got %b want %b",
                             cyc, rsp_ovf, m_ovf);
                end
`endif
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_backpressure();
        test_wrap();
        test_reset_mid_op();
        test_fairness();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
